// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one external memory port between the instruction-cache and the
// data-cache miss/refill paths. Each cache keeps its normal memory-side
// interface and sees an active-low ack as if it owned the bus.
//
// Arbitration:
//   - The data side wins when both caches request in the same IDLE cycle.
//   - A 4-bit streak counter counts back-to-back D grants taken while the
//     I side was waiting. Once it reaches D_STREAK_MAX, the next grant goes to I.
//   - Every grant is followed by one TURN cycle for bus turnaround.
//
// Parameters:
//   WORD_SIZE     address width
//   BUS_SIZE      memory data bus width (one cache line)
//   D_STREAK_MAX  D grants allowed while I waits before I is forced (1..15)
//   TIMEOUT_CYC   grant cycles without mack_n before abort (timeout build only)
//
// Build option:
//   ARB_TIMEOUT_EN  When defined, a grant that sees no mack_n for TIMEOUT_CYC
//                   cycles is aborted. The granted cache gets a one-cycle ack
//                   pulse so it does not hang, and the sticky err flag is set.
//                   When undefined, err is constant 0 and a grant waits
//                   indefinitely.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   i_maddr/i_mreq           icache request (held until ack)
//   i_ack_n/i_mdata          icache ack (active low) and read data
//   d_maddr/d_mreq/d_mwrite  dcache request, write-back (1) or refill (0)
//   d_wdata                  dcache write-back line
//   d_ack_n/d_mdata          dcache ack (active low) and read data
//   mad/mreq/mwrite          memory address, request and write strobe
//   mack_n                   memory ack, a one-cycle active-low pulse
//   mdt_in                   memory read data
//   mdt_out/mdt_oe           memory write data and its drive enable
//   err                      sticky timeout flag
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int BUS_SIZE     = 256,
  parameter int D_STREAK_MAX = 4,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] i_maddr,
  input  logic                 i_mreq,
  output logic                 i_ack_n,
  output logic [BUS_SIZE-1:0]  i_mdata,
  input  logic [WORD_SIZE-1:0] d_maddr,
  input  logic                 d_mreq,
  input  logic                 d_mwrite,
  input  logic [BUS_SIZE-1:0]  d_wdata,
  output logic                 d_ack_n,
  output logic [BUS_SIZE-1:0]  d_mdata,
  output logic [WORD_SIZE-1:0] mad,
  output logic                 mreq,
  output logic                 mwrite,
  input  logic                 mack_n,
  input  logic [BUS_SIZE-1:0]  mdt_in,
  output logic [BUS_SIZE-1:0]  mdt_out,
  output logic                 mdt_oe,
  output logic                 err
);

  // Reject out-of-range configurations at elaboration time.
  if (D_STREAK_MAX < 1 || D_STREAK_MAX > 15 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("mem_bus_arbiter: D_STREAK_MAX must be 1..15 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam logic [3:0] STREAK_LIM = 4'(D_STREAK_MAX);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] streak;
  logic       in_grant;
  logic       enter_i;
  logic       enter_d;
  logic       leave_grant;
  logic       tmo_hit;

  // The streak count holds at 15 instead of wrapping.
  function automatic logic [3:0] streak_sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign in_grant    = (state == GNT_I) || (state == GNT_D);
  assign enter_i     = (state == IDLE) && (state_nxt == GNT_I);
  assign enter_d     = (state == IDLE) && (state_nxt == GNT_D);
  assign leave_grant = in_grant && (state_nxt == TURN);

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // The counter is 0 in the first grant cycle. It fires on the
  // TIMEOUT_CYC-th grant cycle when that cycle still has no mack_n.
  assign tmo_hit = in_grant && mack_n && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= in_grant ? tmo_cnt + TMO_W'(1) : '0;
      if (tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // Next-state decision
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // D wins unless I is waiting and D has already used its streak.
        if (d_mreq && (!i_mreq || (streak < STREAK_LIM))) begin
          state_nxt = GNT_D;
        end else if (i_mreq) begin
          state_nxt = GNT_I;
        end
      end
      GNT_I: begin
        // Ack, requester abort or timeout all release the bus through TURN.
        if (!mack_n || !i_mreq || tmo_hit) begin
          state_nxt = TURN;
        end
      end
      GNT_D: begin
        if (!mack_n || !d_mreq || tmo_hit) begin
          state_nxt = TURN;
        end
      end
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ack routing and data steering
  always_comb begin
    i_ack_n = 1'b1;
    d_ack_n = 1'b1;
    mdt_out = '0;
    case (state)
      // The ack goes through even when the request drops in the same cycle.
      // A timeout forces a one-cycle ack.
      GNT_I: i_ack_n = mack_n && !tmo_hit;
      GNT_D: begin
        d_ack_n = mack_n && !tmo_hit;
        mdt_out = d_wdata;
      end
      default: begin
        i_ack_n = 1'b1;
        d_ack_n = 1'b1;
      end
    endcase
  end

  // Both read buses carry memory data all the time. A cache uses it only
  // while its own ack is low.
  assign i_mdata = mdt_in;
  assign d_mdata = mdt_in;

  // State and grant registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mreq   <= 1'b0;
      mwrite <= 1'b0;
      mdt_oe <= 1'b0;
      mad    <= '0;
      streak <= 4'd0;
    end else begin
      state <= state_nxt;
      if (enter_d) begin
        mad    <= d_maddr;
        mwrite <= d_mwrite;
        mdt_oe <= d_mwrite;
        mreq   <= 1'b1;
        // Only D grants taken while I is waiting count toward starvation.
        streak <= i_mreq ? streak_sat_inc(streak) : 4'd0;
      end else if (enter_i) begin
        mad    <= i_maddr;
        mwrite <= 1'b0;
        mdt_oe <= 1'b0;
        mreq   <= 1'b1;
        streak <= 4'd0;
      end else if (leave_grant) begin
        // mad keeps its value so the address lines do not toggle after a grant.
        mreq   <= 1'b0;
        mwrite <= 1'b0;
        mdt_oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int WS = 32;
  localparam int BS = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [WS-1:0] i_maddr;
  logic          i_mreq;
  logic          i_ack_n;
  logic [BS-1:0] i_mdata;
  logic [WS-1:0] d_maddr;
  logic          d_mreq;
  logic          d_mwrite;
  logic [BS-1:0] d_wdata;
  logic          d_ack_n;
  logic [BS-1:0] d_mdata;
  logic [WS-1:0] mad;
  logic          mreq;
  logic          mwrite;
  logic          mack_n;
  logic [BS-1:0] mdt_in;
  logic [BS-1:0] mdt_out;
  logic          mdt_oe;
  logic          err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .WORD_SIZE(WS),
    .BUS_SIZE(BS),
    .D_STREAK_MAX(4),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_maddr(i_maddr), .i_mreq(i_mreq), .i_ack_n(i_ack_n), .i_mdata(i_mdata),
    .d_maddr(d_maddr), .d_mreq(d_mreq), .d_mwrite(d_mwrite), .d_wdata(d_wdata),
    .d_ack_n(d_ack_n), .d_mdata(d_mdata),
    .mad(mad), .mreq(mreq), .mwrite(mwrite), .mack_n(mack_n),
    .mdt_in(mdt_in), .mdt_out(mdt_out), .mdt_oe(mdt_oe), .err(err)
  );

  typedef struct {
    logic          rst;
    logic          ir;
    logic [WS-1:0] ia;
    logic          dr;
    logic          dw;
    logic [WS-1:0] da;
    logic          mk;
    logic          em;
    logic          ew;
    logic          eo;
    logic [WS-1:0] emad;
    logic          eia;
    logic          eda;
    logic          ews;  // 1: in GNT_D, so mdt_out must equal d_wdata
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic ir, input logic [WS-1:0] ia,
                     input logic dr, input logic dw, input logic [WS-1:0] da,
                     input logic mk, input logic em, input logic ew, input logic eo,
                     input logic [WS-1:0] emad, input logic eia, input logic eda,
                     input logic ews);
    vec_t v;
    v.rst = r;  v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.mk = mk;
    v.em = em;  v.ew = ew; v.eo = eo; v.emad = emad; v.eia = eia; v.eda = eda;
    v.ews = ews;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [BS-1:0] act, input logic [BS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int   grants;
    int   budget;
    logic got_i [10];
    logic exp_i [10];

    rst = 1'b1; i_maddr = '0; i_mreq = 1'b0; d_maddr = '0; d_mreq = 1'b0;
    d_mwrite = 1'b0; d_wdata = '0; mack_n = 1'b1; mdt_in = '0;

    //   rst ir ia        dr dw da        mk | mreq mw oe mad       iack dack ws
    // I-only request, ack 3 cycles after mreq rises
    add(0, 0, 32'h0,    0, 0, 32'h0,    1,   0, 0, 0, 32'h0,    1, 1, 0); // reset state
    add(0, 1, 32'h100,  0, 0, 32'h0,    1,   0, 0, 0, 32'h0,    1, 1, 0);
    add(0, 1, 32'h100,  0, 0, 32'h0,    1,   1, 0, 0, 32'h100,  1, 1, 0);
    add(0, 1, 32'h100,  0, 0, 32'h0,    1,   1, 0, 0, 32'h100,  1, 1, 0);
    add(0, 1, 32'h100,  0, 0, 32'h0,    1,   1, 0, 0, 32'h100,  1, 1, 0);
    add(0, 1, 32'h100,  0, 0, 32'h0,    0,   1, 0, 0, 32'h100,  0, 1, 0);
    add(0, 0, 32'h0,    0, 0, 32'h0,    1,   0, 0, 0, 32'h100,  1, 1, 0); // TURN
    add(0, 0, 32'h0,    0, 0, 32'h0,    1,   0, 0, 0, 32'h100,  1, 1, 0);
    // Both requests together: D write-back first, then I
    add(0, 1, 32'h300,  1, 1, 32'h2000, 1,   0, 0, 0, 32'h100,  1, 1, 0);
    add(0, 1, 32'h300,  1, 1, 32'h2000, 1,   1, 1, 1, 32'h2000, 1, 1, 1);
    add(0, 1, 32'h300,  1, 1, 32'h2000, 0,   1, 1, 1, 32'h2000, 1, 0, 1);
    add(0, 1, 32'h300,  0, 0, 32'h0,    1,   0, 0, 0, 32'h2000, 1, 1, 0); // TURN
    add(0, 1, 32'h300,  0, 0, 32'h0,    1,   0, 0, 0, 32'h2000, 1, 1, 0); // IDLE
    add(0, 1, 32'h300,  0, 0, 32'h0,    0,   1, 0, 0, 32'h300,  0, 1, 0); // GNT_I
    add(0, 0, 32'h0,    0, 0, 32'h0,    1,   0, 0, 0, 32'h300,  1, 1, 0);
    add(0, 0, 32'h0,    0, 0, 32'h0,    1,   0, 0, 0, 32'h300,  1, 1, 0);
    // D request aborted before ack; a late mack_n is ignored
    add(0, 0, 32'h0,    1, 0, 32'h4000, 1,   0, 0, 0, 32'h300,  1, 1, 0);
    add(0, 0, 32'h0,    1, 0, 32'h4000, 1,   1, 0, 0, 32'h4000, 1, 1, 1);
    add(0, 0, 32'h0,    0, 0, 32'h4000, 1,   1, 0, 0, 32'h4000, 1, 1, 1);
    add(0, 0, 32'h0,    0, 0, 32'h0,    1,   0, 0, 0, 32'h4000, 1, 1, 0);
    add(0, 0, 32'h0,    0, 0, 32'h0,    0,   0, 0, 0, 32'h4000, 1, 1, 0);
    add(0, 0, 32'h0,    0, 0, 32'h0,    1,   0, 0, 0, 32'h4000, 1, 1, 0);
    // Request drops in the same cycle as mack_n: ack still forwarded
    add(0, 0, 32'h0,    1, 1, 32'h5000, 1,   0, 0, 0, 32'h4000, 1, 1, 0);
    add(0, 0, 32'h0,    0, 1, 32'h5000, 0,   1, 1, 1, 32'h5000, 1, 0, 1);
    add(0, 0, 32'h0,    0, 0, 32'h0,    1,   0, 0, 0, 32'h5000, 1, 1, 0);
    add(0, 0, 32'h0,    0, 0, 32'h0,    1,   0, 0, 0, 32'h5000, 1, 1, 0);
    // Reset during GNT_D
    add(0, 0, 32'h0,    1, 1, 32'h6000, 1,   0, 0, 0, 32'h5000, 1, 1, 0);
    add(1, 0, 32'h0,    1, 1, 32'h6000, 1,   1, 1, 1, 32'h6000, 1, 1, 1);
    add(0, 0, 32'h0,    0, 0, 32'h0,    0,   0, 0, 0, 32'h0,    1, 1, 0);
    add(0, 0, 32'h0,    0, 0, 32'h0,    1,   0, 0, 0, 32'h0,    1, 1, 0);

    repeat (2) @(posedge clk);

    for (int k = 0; k < vq.size(); k++) begin
      cyc();
      rst = vq[k].rst; i_mreq = vq[k].ir; i_maddr = vq[k].ia;
      d_mreq = vq[k].dr; d_mwrite = vq[k].dw; d_maddr = vq[k].da; mack_n = vq[k].mk;
      d_wdata = {8{32'h5A5A0000 | 32'(k)}};
      mdt_in  = {8{32'hC0DE0000 | 32'(k)}};
      smp();
      chk($sformatf("r%0d.mreq", k),    BS'(mreq),    BS'(vq[k].em));
      chk($sformatf("r%0d.mwrite", k),  BS'(mwrite),  BS'(vq[k].ew));
      chk($sformatf("r%0d.mdt_oe", k),  BS'(mdt_oe),  BS'(vq[k].eo));
      chk($sformatf("r%0d.mad", k),     BS'(mad),     BS'(vq[k].emad));
      chk($sformatf("r%0d.i_ack_n", k), BS'(i_ack_n), BS'(vq[k].eia));
      chk($sformatf("r%0d.d_ack_n", k), BS'(d_ack_n), BS'(vq[k].eda));
      chk($sformatf("r%0d.i_mdata", k), i_mdata, mdt_in);
      chk($sformatf("r%0d.d_mdata", k), d_mdata, mdt_in);
      chk($sformatf("r%0d.err", k),     BS'(err),     BS'(1'b0));
      if (vq[k].ews) begin
        chk($sformatf("r%0d.mdt_out", k), mdt_out, d_wdata);
      end
    end

    // Starvation guard: both sides request continuously, memory acks every
    // grant in its first cycle. Expect D x4, I, D x4, I.
    cyc();
    i_mreq = 1'b1; i_maddr = 32'h8000; d_mreq = 1'b1; d_mwrite = 1'b0;
    d_maddr = 32'h7000; mack_n = 1'b1;
    for (int g = 0; g < 10; g++) begin
      got_i[g] = 1'b0;
      exp_i[g] = (g == 4) || (g == 9);
    end
    grants = 0;
    budget = 0;
    while (grants < 10 && budget < 200) begin
      cyc();
      mack_n = mreq ? 1'b0 : 1'b1;
      smp();
      if (!i_ack_n || !d_ack_n) begin
        chk($sformatf("starve.g%0d.one_ack", grants), BS'(i_ack_n ^ d_ack_n), BS'(1'b1));
        got_i[grants] = !i_ack_n;
        chk($sformatf("starve.g%0d.mad", grants), BS'(mad),
            BS'(!i_ack_n ? 32'h8000 : 32'h7000));
        chk($sformatf("starve.g%0d.mwrite", grants), BS'(mwrite), BS'(1'b0));
        grants++;
      end
      budget++;
    end
    chk("starve.grant_count", BS'(grants), BS'(10));
    for (int g = 0; g < 10; g++) begin
      chk($sformatf("starve.g%0d.is_i", g), BS'(got_i[g]), BS'(exp_i[g]));
    end
    cyc();
    i_mreq = 1'b0; d_mreq = 1'b0; mack_n = 1'b1;
    cyc();
    cyc();

    // Memory never acks an I grant
    cyc();
    i_mreq = 1'b1; i_maddr = 32'h9000; mack_n = 1'b1;
    smp();
    for (int n = 1; n <= 7; n++) begin
      cyc();
      smp();
      chk($sformatf("tmo.c%0d.mreq", n),    BS'(mreq),    BS'(1'b1));
      chk($sformatf("tmo.c%0d.i_ack_n", n), BS'(i_ack_n), BS'(1'b1));
      chk($sformatf("tmo.c%0d.err", n),     BS'(err),     BS'(1'b0));
    end
    cyc();
    smp();
    chk("tmo.c8.mad", BS'(mad), BS'(32'h9000));
    chk("tmo.c8.mreq", BS'(mreq), BS'(1'b1));
`ifdef ARB_TIMEOUT_EN
    chk("tmo.c8.i_ack_n", BS'(i_ack_n), BS'(1'b0));
    chk("tmo.c8.d_ack_n", BS'(d_ack_n), BS'(1'b1));
    cyc();
    i_mreq = 1'b0;
    smp();
    chk("tmo.turn.mreq",    BS'(mreq),    BS'(1'b0));
    chk("tmo.turn.i_ack_n", BS'(i_ack_n), BS'(1'b1));
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("tmo.hold%0d.err", n), BS'(err), BS'(1'b1));
      cyc();
      smp();
    end
`else
    chk("wait.c8.i_ack_n", BS'(i_ack_n), BS'(1'b1));
    for (int n = 9; n <= 20; n++) begin
      cyc();
      smp();
      chk($sformatf("wait.c%0d.mreq", n),    BS'(mreq),    BS'(1'b1));
      chk($sformatf("wait.c%0d.i_ack_n", n), BS'(i_ack_n), BS'(1'b1));
      chk($sformatf("wait.c%0d.err", n),     BS'(err),     BS'(1'b0));
    end
    cyc();
    i_mreq = 1'b0;
    smp();
    chk("wait.abort.still_gnt", BS'(mreq), BS'(1'b1));
    cyc();
    smp();
    chk("wait.abort.mreq", BS'(mreq), BS'(1'b0));
`endif
    cyc();
    rst = 1'b1;
    smp();
    cyc();
    rst = 1'b0;
    smp();
    chk("final_rst.err",  BS'(err),  BS'(1'b0));
    chk("final_rst.mreq", BS'(mreq), BS'(1'b0));
    chk("final_rst.mad",  BS'(mad),  BS'(32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
